// File: rtl/poly_mm_pwm_ctrl_if.sv
// Bus bundle between the pointwise-multiply job controller and its environment
// (sequencer, coefficient RAMs, shared Barrett multiplier).
interface poly_mm_pwm_ctrl_if #(
    parameter int AW = 8
);
    logic          start;
    logic          abort;
    logic          pause;
    logic [23:0]   cfg_q;
    logic [24:0]   cfg_m;
    logic [4:0]    cfg_N;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [23:0]   rd_a_data;
    logic [23:0]   rd_b_data;
    logic          mm_enable;
    logic [23:0]   mm_a;
    logic [23:0]   mm_b;
    logic [23:0]   mm_q;
    logic [24:0]   mm_m;
    logic [4:0]    mm_N;
    logic [1:0]    mm_compress;
    logic [1:0]    mm_decompose;
    logic [1:0]    mm_duv_mode;
    logic          mm_valid;
    logic [23:0]   mm_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;

    // Controller side
    modport slave (
        input  start, abort, pause, cfg_q, cfg_m, cfg_N,
        input  rd_a_data, rd_b_data, mm_valid, mm_result,
        output busy, done, cfg_err, rd_en, rd_addr,
        output mm_enable, mm_a, mm_b, mm_q, mm_m, mm_N,
        output mm_compress, mm_decompose, mm_duv_mode,
        output wr_en, wr_addr, wr_data
    );

    // Sequencer / RAM / multiplier side
    modport master (
        output start, abort, pause, cfg_q, cfg_m, cfg_N,
        output rd_a_data, rd_b_data, mm_valid, mm_result,
        input  busy, done, cfg_err, rd_en, rd_addr,
        input  mm_enable, mm_a, mm_b, mm_q, mm_m, mm_N,
        input  mm_compress, mm_decompose, mm_duv_mode,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/poly_mm_pwm_ctrl.sv
// Pointwise modular-multiply job controller: streams LEN operand pairs through the
// LAT-stage Barrett multiplier and writes results back in order. POLY_MM_PERF_EN adds perf_cycles.
module poly_mm_pwm_ctrl #(
    parameter int LEN = 256,
    parameter int AW  = 8,
    parameter int LAT = 4
) (
    input  logic poly_mm_clk,
    input  logic poly_mm_rst_n,
    poly_mm_pwm_ctrl_if.slave bus
`ifdef POLY_MM_PERF_EN
    ,
    output logic [15:0] perf_cycles
`endif
);

    localparam int FW    = $clog2(LAT + 1);
    localparam int LASTI = LEN - 1;
    // Counters carry one extra bit so LEN == 2**AW terminates without wrapping
    localparam logic [AW:0]   LEN_C  = LEN[AW:0];
    localparam logic [AW:0]   LAST_C = LASTI[AW:0];
    localparam logic [FW-1:0] LAT_C  = LAT[FW-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE,
        S_FLUSH
    } state_e;

    state_e        state_q, state_d;
    logic [AW:0]   rd_cnt_q, rd_cnt_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [23:0]   lat_q_q, lat_q_d;
    logic [24:0]   lat_m_q, lat_m_d;
    logic [4:0]    lat_n_q, lat_n_d;
    logic          mm_en_q, mm_en_d;
    logic          cfg_err_q, cfg_err_d;

    logic cfg_ok;
    logic active;
    logic accept;
    logic rd_en;
    logic wr_en;

    assign cfg_ok = (bus.cfg_N != 5'd0) && (bus.cfg_N <= 5'd24);
    assign active = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign accept = (state_q == S_IDLE) && bus.start && cfg_ok;

    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        flush_cnt_d = flush_cnt_q;
        lat_q_d     = lat_q_q;
        lat_m_d     = lat_m_q;
        lat_n_d     = lat_n_q;
        cfg_err_d   = 1'b0;
        rd_en       = 1'b0;

        // Results landing during an abort cycle or a flush belong to a cancelled job
        wr_en = bus.mm_valid && active && !bus.abort;
        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (!cfg_ok) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        lat_q_d  = bus.cfg_q;
                        lat_m_d  = bus.cfg_m;
                        lat_n_d  = bus.cfg_N;
                        rd_cnt_d = '0;
                        wr_cnt_d = '0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.abort) begin
                    flush_cnt_d = '0;
                    state_d     = S_FLUSH;
                end else begin
                    rd_en = !bus.pause && (rd_cnt_q < LEN_C);
                    if (rd_en) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        if (rd_cnt_q == LAST_C) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    flush_cnt_d = '0;
                    state_d     = S_FLUSH;
                end else if (wr_cnt_d == LEN_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                // Wait out every operation still inside the multiplier pipeline
                if (flush_cnt_q == LAT_C) begin
                    state_d = S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mm_en_d = rd_en;
    end

    always_ff @(posedge poly_mm_clk or negedge poly_mm_rst_n) begin
        if (!poly_mm_rst_n) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            flush_cnt_q <= '0;
            lat_q_q     <= '0;
            lat_m_q     <= '0;
            lat_n_q     <= '0;
            mm_en_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lat_q_q     <= lat_q_d;
            lat_m_q     <= lat_m_d;
            lat_n_q     <= lat_n_d;
            mm_en_q     <= mm_en_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign bus.busy    = active || (state_q == S_FLUSH);
    assign bus.done    = (state_q == S_DONE);
    assign bus.cfg_err = cfg_err_q;
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_cnt_q[AW-1:0];

    // Operands come straight from the RAM read port; zeroed outside an issue slot
    assign bus.mm_enable    = mm_en_q;
    assign bus.mm_a         = mm_en_q ? bus.rd_a_data : 24'd0;
    assign bus.mm_b         = mm_en_q ? bus.rd_b_data : 24'd0;
    assign bus.mm_q         = lat_q_q;
    assign bus.mm_m         = lat_m_q;
    assign bus.mm_N         = lat_n_q;
    assign bus.mm_compress  = 2'b00;
    assign bus.mm_decompose = 2'b00;
    assign bus.mm_duv_mode  = 2'b00;

    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_cnt_q[AW-1:0];
    assign bus.wr_data = wr_en ? bus.mm_result : 24'd0;

`ifdef POLY_MM_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if (active && !bus.abort) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge poly_mm_clk or negedge poly_mm_rst_n) begin
        if (!poly_mm_rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_poly_mm_pwm_ctrl.sv
// Directed bench for poly_mm_pwm_ctrl with a behavioural coefficient RAM and
// LAT-stage modular multiplier around it.
module tb_poly_mm_pwm_ctrl;
    localparam int LEN = 256;
    localparam int AW  = 8;
    localparam int LAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_mm_pwm_ctrl_if #(.AW(AW)) bus ();
`ifdef POLY_MM_PERF_EN
    logic [15:0] perf_cycles;
`endif

    poly_mm_pwm_ctrl #(.LEN(LEN), .AW(AW), .LAT(LAT)) dut (
        .poly_mm_clk   (clk),
        .poly_mm_rst_n (rst_n),
        .bus           (bus)
`ifdef POLY_MM_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    // Coefficient RAM, one cycle read latency
    logic [23:0] mem_a [LEN];
    logic [23:0] mem_b [LEN];
    logic [23:0] exp_mem [LEN];
    logic [23:0] ra, rb;
    assign bus.rd_a_data = ra;
    assign bus.rd_b_data = rb;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra <= '0;
            rb <= '0;
        end else if (bus.rd_en) begin
            ra <= mem_a[bus.rd_addr];
            rb <= mem_b[bus.rd_addr];
        end
    end

    // Multiplier: exact (a*b) mod q after LAT cycles
    logic [LAT-1:0] vpipe;
    logic [23:0]    rpipe [LAT];
    logic [47:0]    prod;
    assign prod = (bus.mm_q == 24'd0) ? 48'd0 :
                  ({24'd0, bus.mm_a} * {24'd0, bus.mm_b}) % {24'd0, bus.mm_q};
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
            for (int i = 0; i < LAT; i++) rpipe[i] <= '0;
        end else begin
            vpipe    <= {vpipe[LAT-2:0], bus.mm_enable};
            rpipe[0] <= prod[23:0];
            for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        end
    end
    assign bus.mm_valid  = vpipe[LAT-1];
    assign bus.mm_result = rpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: write order/data, done pulses, latched configuration stability
    int          base = 0;
    logic [23:0] exp_q = '0;
    logic [4:0]  exp_N = '0;
    int wr_n = 0, wr_bad = 0, done_n = 0, done_cyc = 0, done_busy = 0, cfg_bad = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                if ((wr_n - base) >= LEN || int'(bus.wr_addr) != (wr_n - base) ||
                    bus.wr_data !== exp_mem[(wr_n - base) % LEN])
                    wr_bad <= wr_bad + 1;
                wr_n <= wr_n + 1;
            end
            if (bus.done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
                if (bus.busy) done_busy <= done_busy + 1;
            end
            if (bus.busy && (bus.mm_q !== exp_q || bus.mm_N !== exp_N ||
                bus.mm_compress !== 2'b00 || bus.mm_decompose !== 2'b00 || bus.mm_duv_mode !== 2'b00))
                cfg_bad <= cfg_bad + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int e0 = 0;
    int d0 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle k of a job is the period following edge k-1, edge 0 sampling start
    task automatic wait_cyc(input int k);
        int n = 0;
        while ((cyc - e0 + 1) < k && n < 2000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic set_cfg(input logic [23:0] q, input logic [24:0] m, input logic [4:0] n);
        bus.cfg_q = q;
        bus.cfg_m = m;
        bus.cfg_N = n;
    endtask

    task automatic launch(input logic [23:0] q, input logic [24:0] m, input logic [4:0] n);
        set_cfg(q, m, n);
        exp_q     = q;
        exp_N     = n;
        base      = wr_n;
        d0        = done_n;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_n == d0 && n < 600) begin
            tick(1);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_n != d0), 64'd1);
    endtask

    task automatic fill_const(input logic [23:0] a, input logic [23:0] b, input logic [23:0] r);
        for (int i = 0; i < LEN; i++) begin
            mem_a[i]   = a;
            mem_b[i]   = b;
            exp_mem[i] = r;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        set_cfg('0, '0, '0);
        fill_const(24'd0, 24'd0, 24'd0);

        // Reset state
        tick(3);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
        chk("rst_mm_enable", 64'(bus.mm_enable), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_mm_q", 64'(bus.mm_q), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Job 1: Dilithium modulus, 2*3 = 6 everywhere
        fill_const(24'd2, 24'd3, 24'd6);
        launch(24'd8380417, 25'd8396807, 5'd23);
        chk("j1_rd_en_c1", 64'(bus.rd_en), 64'd1);
        chk("j1_rd_addr_c1", 64'(bus.rd_addr), 64'd0);
        chk("j1_busy_c1", 64'(bus.busy), 64'd1);
        wait_done("j1");
        chk("j1_done_cycle", 64'(done_cyc - e0 + 1), 64'd262);
        chk("j1_writes", 64'(wr_n - base), 64'd256);
        chk("j1_wr_bad", 64'(wr_bad), 64'd0);
        chk("j1_busy_at_done", 64'(done_busy), 64'd0);
`ifdef POLY_MM_PERF_EN
        chk("j1_perf", 64'(perf_cycles), 64'd261);
`endif
        tick(2);

        // Rejected starts: N=0 and N=25
        set_cfg(24'd3329, 25'd5039, 5'd0);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("n0_cfg_err", 64'(bus.cfg_err), 64'd1);
        chk("n0_busy", 64'(bus.busy), 64'd0);
        chk("n0_mm_q_kept", 64'(bus.mm_q), 64'd8380417);
        tick(1);
        chk("n0_cfg_err_clr", 64'(bus.cfg_err), 64'd0);
        bus.cfg_N = 5'd25;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("n25_cfg_err", 64'(bus.cfg_err), 64'd1);
        chk("n25_busy", 64'(bus.busy), 64'd0);
        tick(2);

        // Job 2: Kyber modulus, (-1)*(-1) = 1, with an ignored start mid-job
        fill_const(24'd3328, 24'd3328, 24'd1);
        launch(24'd3329, 25'd5039, 5'd12);
        wait_cyc(30);
        set_cfg(24'd7681, 25'd8736, 5'd13);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("j2_mm_q", 64'(bus.mm_q), 64'd3329);
        chk("j2_mm_N", 64'(bus.mm_N), 64'd12);
        chk("j2_cfg_err", 64'(bus.cfg_err), 64'd0);
        chk("j2_modes", 64'({bus.mm_compress, bus.mm_decompose, bus.mm_duv_mode}), 64'd0);
        wait_done("j2");
        chk("j2_done_cycle", 64'(done_cyc - e0 + 1), 64'd262);
        chk("j2_writes", 64'(wr_n - base), 64'd256);
        chk("j2_wr_bad", 64'(wr_bad), 64'd0);
        chk("j2_cfg_bad", 64'(cfg_bad), 64'd0);
        tick(2);

        // Job 3: varied data, 20 paused ISSUE cycles
        for (int i = 0; i < LEN; i++) begin
            mem_a[i]   = 24'(i + 1000);
            mem_b[i]   = 24'(3 * i + 5);
            exp_mem[i] = 24'(((i + 1000) * (3 * i + 5)) % 3329);
        end
        launch(24'd3329, 25'd5039, 5'd12);
        wait_cyc(20);
        bus.pause = 1'b1;
        #1;
        chk("j3_pause_rd_en", 64'(bus.rd_en), 64'd0);
        tick(10);
        for (int i = 0; i < 20; i++) begin
            bus.pause = (i % 2 == 0);
            tick(1);
        end
        bus.pause = 1'b0;
        wait_done("j3");
        chk("j3_done_cycle", 64'(done_cyc - e0 + 1), 64'd282);
        chk("j3_writes", 64'(wr_n - base), 64'd256);
        chk("j3_wr_bad", 64'(wr_bad), 64'd0);
        tick(2);

        // Job 4: abort at cycle 50, then a clean rerun
        launch(24'd3329, 25'd5039, 5'd12);
        wait_cyc(50);
        bus.abort = 1'b1;
        #1;
        chk("j4_abort_rd_en", 64'(bus.rd_en), 64'd0);
        chk("j4_abort_wr_en", 64'(bus.wr_en), 64'd0);
        tick(1);
        bus.abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("j4_flush_busy", 64'(bus.busy), 64'd1);
            tick(1);
        end
        chk("j4_idle_busy", 64'(bus.busy), 64'd0);
        tick(5);
        chk("j4_writes", 64'(wr_n - base), 64'd44);
        chk("j4_no_done", 64'(done_n - d0), 64'd0);
        launch(24'd3329, 25'd5039, 5'd12);
        wait_done("j4r");
        chk("j4r_done_cycle", 64'(done_cyc - e0 + 1), 64'd262);
        chk("j4r_writes", 64'(wr_n - base), 64'd256);
        chk("j4r_wr_bad", 64'(wr_bad), 64'd0);
        tick(2);

        // Job 5: async reset at cycle 100, then a full job
        launch(24'd3329, 25'd5039, 5'd12);
        wait_cyc(100);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 64'(bus.busy), 64'd0);
        chk("ar_rd_en", 64'(bus.rd_en), 64'd0);
        chk("ar_mm_enable", 64'(bus.mm_enable), 64'd0);
        chk("ar_wr_en", 64'(bus.wr_en), 64'd0);
        chk("ar_mm_q", 64'(bus.mm_q), 64'd0);
        chk("ar_rd_addr", 64'(bus.rd_addr), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("ar_no_done", 64'(done_n - d0), 64'd0);
        launch(24'd3329, 25'd5039, 5'd12);
        wait_done("ar");
        chk("ar_done_cycle", 64'(done_cyc - e0 + 1), 64'd262);
        chk("ar_writes", 64'(wr_n - base), 64'd256);
        chk("ar_wr_bad", 64'(wr_bad), 64'd0);
        chk("ar_cfg_bad", 64'(cfg_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
